// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the multiply/divide sequencer: op codes, default
// latencies, FSM state codes and the packed HI/LO result record.
package muldiv_ctrl_pkg;

  // Op codes presented on the op bus by the E stage
  localparam logic [2:0] MD_MULTU = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_DIVU  = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  // Default busy periods
  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;

  // Sequencer state codes
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // HI/LO pair as produced by the arithmetic block
  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } md_res_t;

  // True for the four ops that occupy the multi-cycle unit
  function automatic logic is_arith_op(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// E-stage <-> multiply/divide unit bus. The pipeline side is the master,
// the sequencer is the slave.
interface muldiv_ctrl_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        md_D;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b, md_D,
    input  busy, md_stall, hi, lo
  );

  modport slave (
    input  start, op, a, b, md_D,
    output busy, md_stall, hi, lo
  );
endinterface

// File: rtl/muldiv_ctrl_arith.sv
// Combinational multiply/divide datapath. Produces the full 64-bit {hi,lo}
// result for the captured op and flags division by zero so the sequencer
// can suppress the commit.
module md_arith
  import muldiv_ctrl_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output md_res_t     res,
  output logic        div0
);

  logic [63:0]        res_vec_s;
  logic signed [31:0] sa_s;
  logic signed [31:0] sb_s;

  assign sa_s = a;
  assign sb_s = b;
  assign res  = md_res_t'(res_vec_s);

  // Select product or {remainder, quotient} for the op; INT_MIN/-1 is
  // pinned explicitly so the wrap-around result never depends on the simulator
  always_comb begin
    res_vec_s = 64'd0;
    div0      = 1'b0;
    case (op)
      MD_MULTU: res_vec_s = {32'd0, a} * {32'd0, b};
      MD_MULT:  res_vec_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      MD_DIVU: begin
        if (b == 32'd0) begin
          div0 = 1'b1;
        end else begin
          res_vec_s = {a % b, a / b};
        end
      end
      MD_DIV: begin
        if (b == 32'd0) begin
          div0 = 1'b1;
        end else if ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
          res_vec_s = {32'h0000_0000, 32'h8000_0000};
        end else begin
          res_vec_s = {sa_s % sb_s, sa_s / sb_s};
        end
      end
      default: res_vec_s = 64'd0;
    endcase
  end

endmodule

// File: rtl/muldiv_ctrl_chk.sv
// Simulation-side observer for the sequencer bus. Records any start that
// arrives while an operation is in flight; such a start is dropped by the
// sequencer and should have been held off by md_stall.
module muldiv_ctrl_chk (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic busy,
  output logic start_while_busy
);

  // Sticky flag: set on the first start seen during busy, cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      start_while_busy <= 1'b0;
    end else if (start && busy) begin
      start_while_busy <= 1'b1;
    end else begin
      start_while_busy <= start_while_busy;
    end
  end

  cover_start_while_busy: cover property (@(posedge clk) disable iff (reset) start && busy);

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle multiply/divide sequencer with architectural HI/LO registers.
// Captures op/operands on start, holds busy for a fixed latency, then
// commits the result. md_stall freezes D-stage md-class instructions.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input  logic          clk,
  input  logic          reset,
  muldiv_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(DIV_CYC + 1);

  logic [0:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       op_r;
  logic [31:0]      a_r;
  logic [31:0]      b_r;
  logic [31:0]      hi_r;
  logic [31:0]      lo_r;
  logic             busy_r;
  md_res_t          res_s;
  logic             div0_s;
  logic             accept_s;

  md_arith u_arith (
    .op   (op_r),
    .a    (a_r),
    .b    (b_r),
    .res  (res_s),
    .div0 (div0_s)
  );

  assign accept_s     = bus.start && (state_r == ST_IDLE) && is_arith_op(bus.op);
  assign bus.busy     = busy_r;
  assign bus.hi       = hi_r;
  assign bus.lo       = lo_r;
  assign bus.md_stall = bus.md_D && (bus.start || busy_r);

  // Sequencer FSM: capture on accept, count down the latency, commit at 1
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      op_r    <= 3'd0;
      a_r     <= 32'd0;
      b_r     <= 32'd0;
      hi_r    <= 32'd0;
      lo_r    <= 32'd0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_r <= ST_RUN;
            busy_r  <= 1'b1;
            op_r    <= bus.op;
            a_r     <= bus.a;
            b_r     <= bus.b;
            cnt_r   <= bus.op[1] ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
          end else if (bus.start && (bus.op == MD_MTHI)) begin
            hi_r <= bus.a;
          end else if (bus.start && (bus.op == MD_MTLO)) begin
            lo_r <= bus.a;
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_RUN: begin
          if (cnt_r == CNT_W'(1)) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
            if (!div0_s) begin
              hi_r <= res_s.hi;
              lo_r <= res_s.lo;
            end else begin
              hi_r <= hi_r;
              lo_r <= lo_r;
            end
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          cnt_r   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

endmodule
